// File: rtl/add_accumulator.sv
// ---------------------------------------------------------------------------
// add_accumulator
//
// Sums a burst of unsigned operands and presents the total, the operand count
// and a sticky carry-out flag once the last operand of the burst is accepted.
// The result is held until the consumer takes it. The operand that arrives in
// the same cycle the result is taken opens the next burst with no bubble.
//
// Ports
//   clk        rising-edge clock for all state
//   rst        synchronous active-high reset; highest priority
//   clear      synchronous burst abort; discards a partial or unconsumed result
//   in_valid   operand present on in_data
//   in_ready   block can accept an operand this cycle
//   in_data    unsigned operand, DATA_W bits
//   in_last    operand is the final one of its burst
//   out_valid  burst result present
//   out_ready  consumer takes the result this cycle
//   out_sum    burst sum modulo 2^ACC_W
//   out_count  operands in the burst, saturating at 255
//   out_ovf    accumulator carried out of its top bit during the burst
// ---------------------------------------------------------------------------
module add_accumulator #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [7:0]        out_count,
  output logic              out_ovf
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [ACC_W-1:0]  acc_q;
  logic [7:0]        count_q;
  logic              ovf_q;
  logic              accept;
  logic              start;
  logic [ACC_W:0]    sum_ext;

  // Handshake outputs depend only on the state, except that in DONE the block
  // can take a new operand exactly when the held result is being consumed.
  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    if (state_q == DONE) begin
      out_valid = 1'b1;
      in_ready  = out_ready;
    end
  end

  // An operand that arrives outside ACCUM always opens a new burst. The add is
  // one bit wider than the accumulator so the top bit is the carry-out.
  always_comb begin
    accept  = in_valid && in_ready;
    start   = accept && (state_q != ACCUM);
    sum_ext = (ACC_W + 1)'(acc_q) + (ACC_W + 1)'(in_data);
  end

  // Next-state logic; clear overrides any handshake in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = in_last ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          state_d = in_last ? DONE : ACCUM;
        end
      end
      DONE: begin
        if (out_ready) begin
          if (in_valid) begin
            state_d = in_last ? DONE : ACCUM;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (clear) begin
      state_d = IDLE;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Accumulator, count and overflow registers. They only move on an accepted
  // operand, so they naturally hold while a result waits in DONE. A cleared
  // operand is dropped, leaving the stale values invisible until the next
  // burst reloads them.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (!clear && accept) begin
      if (start) begin
        acc_q   <= ACC_W'(in_data);
        count_q <= 8'd1;
        ovf_q   <= 1'b0;
      end else begin
        acc_q   <= sum_ext[ACC_W-1:0];
        count_q <= (count_q == 8'hFF) ? count_q : count_q + 8'd1;
        ovf_q   <= ovf_q | sum_ext[ACC_W];
      end
    end
  end

  // Results come straight from the registers.
  always_comb begin
    out_sum   = acc_q;
    out_count = count_q;
    out_ovf   = ovf_q;
  end

endmodule

// File: tb/tb_add_accumulator.sv
// ---------------------------------------------------------------------------
// tb_add_accumulator
//
// Drives add_accumulator with directed bursts followed by random traffic.
// A reference model tracks each burst as a plain running total and operand
// count and derives the wrapped sum, saturated count and overflow flag from
// them. Every cycle the DUT handshake and any presented result are compared
// against the model; a few hand-computed values pin the model itself.
// ---------------------------------------------------------------------------
module tb_add_accumulator;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              clear = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_last = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [ACC_W-1:0]  out_sum;
  logic [7:0]        out_count;
  logic              out_ovf;

  int checks = 0;
  int failures = 0;
  bit checking = 1'b0;

  // Reference model: the burst in progress and the result awaiting the consumer.
  bit          busy = 1'b0;
  longint      bsum = 0;
  int          bn = 0;
  bit          have_res = 1'b0;
  logic [15:0] res_sum = '0;
  logic [7:0]  res_cnt = '0;
  logic        res_ovf = 1'b0;

  add_accumulator #(
    .DATA_W(DATA_W),
    .ACC_W (ACC_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_count(out_count),
    .out_ovf  (out_ovf)
  );

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  // Single comparison point; every check in the bench goes through here.
  task automatic checkValue(input string name, input logic [31:0] act,
                            input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at t=%0t", name, act, req, $time);
    end
  endtask

  // Compare the DUT against the model for the current cycle.
  task automatic checkOutput();
    if (!checking) return;
    checkValue("in_ready", {31'b0, in_ready}, have_res ? {31'b0, out_ready} : 32'd1);
    checkValue("out_valid", {31'b0, out_valid}, {31'b0, have_res});
    if (have_res) begin
      checkValue("out_sum", {16'b0, out_sum}, {16'b0, res_sum});
      checkValue("out_count", {24'b0, out_count}, {24'b0, res_cnt});
      checkValue("out_ovf", {31'b0, out_ovf}, {31'b0, res_ovf});
    end
  endtask

  // Advance the model by one clock edge using the inputs of this cycle.
  task automatic updateModel(input bit r, input bit c, input bit v,
                             input logic [7:0] d, input bit l, input bit o);
    bit acc_ok;
    if (r || c) begin
      busy     = 1'b0;
      have_res = 1'b0;
    end else begin
      acc_ok = v && (have_res ? o : 1'b1);
      if (have_res && o) have_res = 1'b0;
      if (acc_ok) begin
        if (!busy) begin
          bsum = 0;
          bn   = 0;
          busy = 1'b1;
        end
        bsum += longint'(d);
        bn++;
        if (l) begin
          have_res = 1'b1;
          busy     = 1'b0;
          res_sum  = bsum[15:0];
          res_cnt  = (bn > 255) ? 8'd255 : 8'(bn);
          res_ovf  = (bsum > 65535);
        end
      end
    end
  endtask

  // One clock cycle: drive inputs on the falling edge, check, then step the model.
  task automatic applyStimulus(input bit r, input bit c, input bit v,
                               input logic [7:0] d, input bit l, input bit o);
    @(negedge clk);
    rst       = r;
    clear     = c;
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = o;
    #1;
    checkOutput();
    updateModel(r, c, v, d, l, o);
  endtask

  initial begin
    $display("[TB] start");

    // Reset; outputs are unknown before the first edge so skip that check.
    applyStimulus(1, 0, 0, 8'h00, 0, 0);
    checking = 1'b1;
    applyStimulus(1, 0, 0, 8'h00, 0, 0);
    checkValue("rst_out_valid", {31'b0, out_valid}, 32'd0);
    checkValue("rst_in_ready", {31'b0, in_ready}, 32'd1);
    checkValue("rst_out_sum", {16'b0, out_sum}, 32'd0);
    checkValue("rst_out_count", {24'b0, out_count}, 32'd0);
    checkValue("rst_out_ovf", {31'b0, out_ovf}, 32'd0);

    // Three-operand burst.
    applyStimulus(0, 0, 1, 8'h10, 0, 1);
    applyStimulus(0, 0, 1, 8'h20, 0, 1);
    applyStimulus(0, 0, 1, 8'h30, 1, 1);
    applyStimulus(0, 0, 0, 8'h00, 0, 1);
    checkValue("b3_out_valid", {31'b0, out_valid}, 32'd1);
    checkValue("b3_out_sum", {16'b0, out_sum}, 32'h0060);
    checkValue("b3_out_count", {24'b0, out_count}, 32'd3);
    checkValue("b3_out_ovf", {31'b0, out_ovf}, 32'd0);

    // Long burst: count saturates and the sum wraps.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(0, 0, 1, 8'hFF, (i == 299), 0);
    end
    applyStimulus(0, 0, 0, 8'h00, 0, 0);
    checkValue("long_model_sum", {16'b0, res_sum}, 32'h2AD4);
    checkValue("long_out_sum", {16'b0, out_sum}, 32'h2AD4);
    checkValue("long_out_count", {24'b0, out_count}, 32'd255);
    checkValue("long_out_ovf", {31'b0, out_ovf}, 32'd1);
    applyStimulus(0, 0, 0, 8'h00, 0, 1);

    // Single-operand burst held under back-pressure while operands are offered.
    applyStimulus(0, 0, 1, 8'h7F, 1, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 1, 8'($urandom_range(0, 255)), 0, 0);
      checkValue("hold_out_valid", {31'b0, out_valid}, 32'd1);
      checkValue("hold_out_sum", {16'b0, out_sum}, 32'h007F);
      checkValue("hold_out_count", {24'b0, out_count}, 32'd1);
      checkValue("hold_out_ovf", {31'b0, out_ovf}, 32'd0);
      checkValue("hold_in_ready", {31'b0, in_ready}, 32'd0);
    end

    // Result taken and a new burst started in the same cycle.
    applyStimulus(0, 0, 1, 8'h05, 0, 1);
    applyStimulus(0, 0, 0, 8'h00, 0, 0);
    checkValue("chain_out_valid", {31'b0, out_valid}, 32'd0);
    checkValue("chain_in_ready", {31'b0, in_ready}, 32'd1);
    checkValue("chain_acc", {16'b0, out_sum}, 32'h0005);
    checkValue("chain_count", {24'b0, out_count}, 32'd1);

    // Clear wins over a simultaneous accept; the next burst starts clean.
    applyStimulus(0, 1, 0, 8'h00, 0, 0);
    applyStimulus(0, 0, 1, 8'h01, 0, 0);
    applyStimulus(0, 0, 1, 8'h02, 0, 0);
    applyStimulus(0, 1, 1, 8'h44, 0, 0);
    applyStimulus(0, 0, 0, 8'h00, 0, 0);
    checkValue("clr_out_valid", {31'b0, out_valid}, 32'd0);
    checkValue("clr_in_ready", {31'b0, in_ready}, 32'd1);
    applyStimulus(0, 0, 1, 8'h03, 1, 1);
    applyStimulus(0, 0, 0, 8'h00, 0, 1);
    checkValue("clr_out_sum", {16'b0, out_sum}, 32'h0003);
    checkValue("clr_out_count", {24'b0, out_count}, 32'd1);

    // Reset while a result is held discards it.
    applyStimulus(0, 0, 1, 8'h10, 0, 0);
    applyStimulus(0, 0, 1, 8'h20, 0, 0);
    applyStimulus(0, 0, 1, 8'h30, 1, 0);
    applyStimulus(0, 0, 0, 8'h00, 0, 0);
    checkValue("rstd_pre_sum", {16'b0, out_sum}, 32'h0060);
    applyStimulus(1, 0, 0, 8'h00, 0, 0);
    applyStimulus(0, 0, 0, 8'h00, 0, 0);
    checkValue("rstd_out_valid", {31'b0, out_valid}, 32'd0);
    checkValue("rstd_in_ready", {31'b0, in_ready}, 32'd1);
    checkValue("rstd_out_sum", {16'b0, out_sum}, 32'd0);

    // Random traffic with occasional reset and clear.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 199) == 0,
                    $urandom_range(0, 49) == 0,
                    $urandom_range(0, 9) < 7,
                    8'($urandom_range(0, 255)),
                    $urandom_range(0, 5) == 0,
                    $urandom_range(0, 2) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/add_accumulator.md
ADD_ACCUMULATOR -- requirements
Module: add_accumulator

Interface
REQ-001 Parameter DATA_W, default 8: width of each input operand byte.
REQ-002 Parameter ACC_W, default 16: width of the running accumulator; SHALL be >= DATA_W.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 clear  input  1  synchronous burst abort.
REQ-006 in_valid  input  1  operand present on in_data.
REQ-007 in_ready  output  1  block can accept an operand this cycle.
REQ-008 in_data  input  DATA_W  unsigned operand.
REQ-009 in_last  input  1  operand is the final one of its burst.
REQ-010 out_valid  output  1  burst result present.
REQ-011 out_ready  input  1  consumer takes the result this cycle.
REQ-012 out_sum  output  ACC_W  sum of the burst, modulo 2^ACC_W.
REQ-013 out_count  output  8  operands in the burst, saturating at 255.
REQ-014 out_ovf  output  1  sticky: accumulator carried out of bit ACC_W-1 during the burst.

Function
REQ-015 An operand SHALL be accepted only on a cycle with in_valid=1 and in_ready=1.
REQ-016 A result SHALL be transferred only on a cycle with out_valid=1 and out_ready=1.
REQ-017 The FSM SHALL have three states: IDLE, ACCUM and DONE.
REQ-018 In IDLE and ACCUM, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-019 In DONE, out_valid SHALL be 1 and in_ready SHALL equal out_ready.
REQ-020 An accept in IDLE SHALL load acc={zero-extended in_data}, count=1 and ovf=0.
REQ-021 An accept in IDLE SHALL then go to DONE if in_last=1, otherwise to ACCUM.
REQ-022 An accept in ACCUM SHALL set acc=acc+in_data (ACC_W-bit wrap) and count=min(count+1,255).
REQ-023 An accept in ACCUM SHALL set ovf=1 if that add carries out of bit ACC_W-1; ovf SHALL remain set until the next burst starts.
REQ-024 An accept in ACCUM with in_last=1 SHALL go to DONE; otherwise the FSM SHALL stay in ACCUM.
REQ-025 The result SHALL appear with latency 1: out_valid SHALL rise in the cycle after the in_last accept.
REQ-026 out_sum, out_count and out_ovf SHALL stay stable while out_valid=1 and out_ready=0.
REQ-027 In DONE with out_ready=1 and in_valid=0, the FSM SHALL go to IDLE.
REQ-028 In DONE with out_ready=1 and in_valid=1, the result SHALL be transferred and the operand SHALL start a new burst as in REQ-020/021, with no bubble cycle.
REQ-029 In ACCUM with in_valid=0, state, acc, count and ovf SHALL hold.
REQ-030 clear=1 SHALL force IDLE on the next edge, discarding any partial or unconsumed result.
REQ-031 clear SHALL take priority over a simultaneous accept or transfer; an operand presented that cycle SHALL NOT be counted.
REQ-032 out_sum, out_count and out_ovf SHALL be driven directly from the acc, count and ovf registers, with no combinational path from in_data.

Reset
REQ-033 rst SHALL take priority over clear and all handshakes.
REQ-034 While rst=1 and on the edge after it, state SHALL be IDLE, acc=0, count=0, ovf=0, out_valid=0 and in_ready=1.
REQ-035 Asserting rst mid-burst or in DONE SHALL discard the burst; no result SHALL be presented for it afterwards.

Verification
REQ-036 Burst 0x10, 0x20, 0x30(last) with out_ready=1 -> one cycle later out_valid=1, out_sum=0x0060, out_count=3, out_ovf=0.
REQ-037 Burst of 300 operands of 0xFF (ACC_W=16) -> out_sum=0x2AD4, out_count=255, out_ovf=1 (sum 76500 wraps).
REQ-038 Single-operand burst 0x7F(last) with out_ready=0 for 5 cycles -> out_valid=1 and outputs stable at 0x007F/1/0 for all 5 cycles, and in_ready=0.
REQ-039 DONE with out_ready=1, in_valid=1, in_data=0x05, in_last=0 -> old result transferred, state ACCUM with acc=0x0005 and count=1 on the next cycle.
REQ-040 clear=1 together with an accept of 0x44 in ACCUM after 0x01, 0x02 -> next cycle IDLE, out_valid=0; a following burst 0x03(last) -> out_sum=0x0003, out_count=1.
REQ-041 rst=1 pulsed one cycle while in DONE holding 0x0060 -> out_valid=0, in_ready=1, out_sum=0 on the next cycle.
